// File: rtl/tri_setup.sv
// rtl/tri_setup.sv - triangle setup: edge equations, twice-area, tile-clamped bbox, cull/winding fix
// Define BACKFACE_CULL_EN to cull negative-area triangles instead of flipping their winding.
module tri_setup #(
   parameter int TILE_SIZE = 32,
   localparam int BW = $clog2(TILE_SIZE)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fifo_empty,
   output logic            fifo_rd_en,
   input  logic [121:0]    fifo_rd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_is_tile,
   output logic [3:0]      out_tile_x,
   output logic [2:0]      out_tile_y,
   output logic [20:0]     out_edge_a,
   output logic [20:0]     out_edge_b,
   output logic [38:0]     out_edge_c,
   output logic [14:0]     out_area,
   output logic [4*BW-1:0] out_bbox,
   output logic [77:0]     out_attr,
   output logic [15:0]     culled_count
);

   typedef enum logic [2:0] {IDLE, CAPT, E0, E1, E2, AREA, OUT} state_t;
   state_t state_q, state_d;

   logic [113:0]    vtx_q;
   logic [6:0]      ea_q [3];
   logic [6:0]      eb_q [3];
   logic [12:0]     ec_q [3];
   logic [14:0]     area_q;
   logic [4*BW-1:0] bbox_q;
   logic            offscr_q;
   logic            is_tile_q;
   logic [3:0]      tile_x_q;
   logic [2:0]      tile_y_q;
   logic [15:0]     cnt_q;

   logic [11:0] vp, vq;
   logic [1:0]  edge_idx;
   logic [5:0]  xp, yp, xq, yq;
   logic [11:0] prod_pq, prod_qp;
   logic [6:0]  edge_a, edge_b;
   logic [12:0] edge_c;
   logic [5:0]  xa, xb, xc, ya, yb, yc;
   logic [5:0]  min_x, max_x, min_y, max_y;
   logic [14:0] area_sum;
   logic        cull;

   // One multiplier pair serves all three edges; the FSM state picks the vertex pair.
   always_comb begin
      vp       = vtx_q[113:102];
      vq       = vtx_q[75:64];
      edge_idx = 2'd0;
      case (state_q)
         E1: begin vp = vtx_q[75:64];  vq = vtx_q[37:26];  edge_idx = 2'd1; end
         E2: begin vp = vtx_q[37:26];  vq = vtx_q[113:102]; edge_idx = 2'd2; end
         default: ;
      endcase
   end

   assign xp      = vp[11:6];
   assign yp      = vp[5:0];
   assign xq      = vq[11:6];
   assign yq      = vq[5:0];
   assign prod_pq = {6'd0, xp} * {6'd0, yq};
   assign prod_qp = {6'd0, xq} * {6'd0, yp};
   assign edge_a  = {1'b0, yp} - {1'b0, yq};
   assign edge_b  = {1'b0, xq} - {1'b0, xp};
   assign edge_c  = {1'b0, prod_pq} - {1'b0, prod_qp};

   assign xa = vtx_q[113:108];
   assign ya = vtx_q[107:102];
   assign xb = vtx_q[75:70];
   assign yb = vtx_q[69:64];
   assign xc = vtx_q[37:32];
   assign yc = vtx_q[31:26];

   function automatic logic [5:0] min3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      logic [5:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [5:0] max3(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      logic [5:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   function automatic logic [BW-1:0] clamp(input logic [5:0] v);
      if (32'(v) > TILE_SIZE - 1)
         return BW'(TILE_SIZE - 1);
      else
         return v[BW-1:0];
   endfunction

   assign min_x = min3(xa, xb, xc);
   assign max_x = max3(xa, xb, xc);
   assign min_y = min3(ya, yb, yc);
   assign max_y = max3(ya, yb, yc);

   assign area_sum = {{2{ec_q[0][12]}}, ec_q[0]} + {{2{ec_q[1][12]}}, ec_q[1]}
                   + {{2{ec_q[2][12]}}, ec_q[2]};

`ifdef BACKFACE_CULL_EN
   assign cull = (area_sum == 15'd0) || area_sum[14] || offscr_q;
`else
   assign cull = (area_sum == 15'd0) || offscr_q;
`endif

   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            fifo_rd_en = !fifo_empty && !rst;
            if (fifo_rd_en)
               state_d = CAPT;
         end
         CAPT:    state_d = fifo_rd_data[121] ? OUT : E0;
         E0:      state_d = E1;
         E1:      state_d = E2;
         E2:      state_d = AREA;
         AREA:    state_d = cull ? IDLE : OUT;
         OUT:     if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         vtx_q     <= '0;
         area_q    <= '0;
         bbox_q    <= '0;
         offscr_q  <= 1'b0;
         is_tile_q <= 1'b0;
         tile_x_q  <= '0;
         tile_y_q  <= '0;
         cnt_q     <= '0;
         for (int i = 0; i < 3; i++) begin
            ea_q[i] <= '0;
            eb_q[i] <= '0;
            ec_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            CAPT: begin
               vtx_q     <= fifo_rd_data[113:0];
               is_tile_q <= fifo_rd_data[121];
               if (fifo_rd_data[121]) begin
                  tile_x_q <= fifo_rd_data[117:114];
                  tile_y_q <= fifo_rd_data[120:118];
               end
            end
            E0, E1, E2: begin
               ea_q[edge_idx] <= edge_a;
               eb_q[edge_idx] <= edge_b;
               ec_q[edge_idx] <= edge_c;
               if (state_q == E2) begin
                  bbox_q   <= {clamp(min_x), clamp(max_x), clamp(min_y), clamp(max_y)};
                  offscr_q <= (32'(min_x) >= TILE_SIZE) || (32'(min_y) >= TILE_SIZE);
               end
            end
            AREA: begin
               if (cull) begin
                  if (cnt_q != 16'hFFFF)
                     cnt_q <= cnt_q + 16'd1;
               end else if (area_sum[14]) begin
                  // Clockwise triangle: flip every coefficient so the record is always CCW.
                  for (int i = 0; i < 3; i++) begin
                     ea_q[i] <= -ea_q[i];
                     eb_q[i] <= -eb_q[i];
                     ec_q[i] <= -ec_q[i];
                  end
                  area_q <= -area_sum;
               end else begin
                  area_q <= area_sum;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid    = (state_q == OUT);
   assign out_is_tile  = is_tile_q;
   assign out_tile_x   = tile_x_q;
   assign out_tile_y   = tile_y_q;
   assign out_edge_a   = {ea_q[0], ea_q[1], ea_q[2]};
   assign out_edge_b   = {eb_q[0], eb_q[1], eb_q[2]};
   assign out_edge_c   = {ec_q[0], ec_q[1], ec_q[2]};
   assign out_area     = area_q;
   assign out_bbox     = bbox_q;
   assign out_attr     = {vtx_q[101:76], vtx_q[63:38], vtx_q[25:0]};
   assign culled_count = cnt_q;

endmodule

// File: tb/tb_tri_setup.sv
// tb/tb_tri_setup.sv - randomized self-checking bench for tri_setup against an arithmetic reference model
module tb_tri_setup;
   localparam int TS = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         fifo_empty = 1'b1;
   logic         fifo_rd_en;
   logic [121:0] fifo_rd_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_is_tile;
   logic [3:0]   out_tile_x;
   logic [2:0]   out_tile_y;
   logic [20:0]  out_edge_a;
   logic [20:0]  out_edge_b;
   logic [38:0]  out_edge_c;
   logic [14:0]  out_area;
   logic [19:0]  out_bbox;
   logic [77:0]  out_attr;
   logic [15:0]  culled_count;

   tri_setup #(.TILE_SIZE(TS)) dut (
      .clk(clk), .rst(rst),
      .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_is_tile(out_is_tile),
      .out_tile_x(out_tile_x), .out_tile_y(out_tile_y),
      .out_edge_a(out_edge_a), .out_edge_b(out_edge_b), .out_edge_c(out_edge_c),
      .out_area(out_area), .out_bbox(out_bbox), .out_attr(out_attr),
      .culled_count(culled_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_tile;
      logic [3:0]  tx;
      logic [2:0]  ty;
      logic [20:0] ea, eb;
      logic [38:0] ec;
      logic [14:0] area;
      logic [19:0] bbox;
      logic [77:0] attr;
   } rec_t;

   int           nvec = 0, nerr = 0, cyc = 0, rd_cnt = 0, n_push = 0;
   bit           do_pop;
   logic [121:0] q_words[$];
   rec_t         exp_q[$];
   rec_t         mon_r;
   logic [3:0]   m_tx = '0;
   logic [2:0]   m_ty = '0;
   logic [15:0]  m_cnt = '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic int clampv(input int v);
      return (v > TS - 1) ? TS - 1 : v;
   endfunction

   // Reference: straight arithmetic on the decoded vertices, applied when the DUT pops a word.
   task automatic model_pop(input logic [121:0] w);
      rec_t r;
      int x[3], y[3], a[3], b[3], c[3];
      int area, mnx, mxx, mny, mxy;
      bit cull;
      logic [37:0] v;
      r = '{default: '0};
      if (w[121]) begin
         m_tx = w[117:114];
         m_ty = w[120:118];
         r.is_tile = 1'b1; r.tx = m_tx; r.ty = m_ty;
         exp_q.push_back(r);
         return;
      end
      for (int i = 0; i < 3; i++) begin
         v = 38'(w >> (76 - 38 * i));
         x[i] = int'(v[37:32]);
         y[i] = int'(v[31:26]);
      end
      area = 0;
      for (int e = 0; e < 3; e++) begin
         a[e] = y[e] - y[(e + 1) % 3];
         b[e] = x[(e + 1) % 3] - x[e];
         c[e] = x[e] * y[(e + 1) % 3] - x[(e + 1) % 3] * y[e];
         area += c[e];
      end
      mnx = x[0]; mxx = x[0]; mny = y[0]; mxy = y[0];
      for (int i = 1; i < 3; i++) begin
         if (x[i] < mnx) mnx = x[i];
         if (x[i] > mxx) mxx = x[i];
         if (y[i] < mny) mny = y[i];
         if (y[i] > mxy) mxy = y[i];
      end
      cull = (area == 0) || (mnx >= TS) || (mny >= TS);
`ifdef BACKFACE_CULL_EN
      if (area < 0) cull = 1'b1;
`endif
      if (cull) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         return;
      end
      if (area < 0) begin
         for (int e = 0; e < 3; e++) begin
            a[e] = -a[e]; b[e] = -b[e]; c[e] = -c[e];
         end
         area = -area;
      end
      r.is_tile = 1'b0; r.tx = m_tx; r.ty = m_ty;
      r.ea   = {7'(a[0]), 7'(a[1]), 7'(a[2])};
      r.eb   = {7'(b[0]), 7'(b[1]), 7'(b[2])};
      r.ec   = {13'(c[0]), 13'(c[1]), 13'(c[2])};
      r.area = 15'(area);
      r.bbox = {5'(clampv(mnx)), 5'(clampv(mxx)), 5'(clampv(mny)), 5'(clampv(mxy))};
      r.attr = {w[101:76], w[63:38], w[25:0]};
      exp_q.push_back(r);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Vertex FIFO: pop observed on the falling edge, data presented just after the next rising edge.
   always begin
      @(negedge clk);
      do_pop = fifo_rd_en && !rst;
      if (do_pop) rd_cnt++;
      @(posedge clk);
      #1;
      if (do_pop && q_words.size() > 0) begin
         fifo_rd_data = q_words.pop_front();
         model_pop(fifo_rd_data);
      end
      fifo_empty = (q_words.size() == 0);
   end

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rec", 128'(1), 128'(0));
         end else begin
            mon_r = exp_q.pop_front();
            check("rec_is_tile", 128'(out_is_tile), 128'(mon_r.is_tile));
            check("rec_tile_x", 128'(out_tile_x), 128'(mon_r.tx));
            check("rec_tile_y", 128'(out_tile_y), 128'(mon_r.ty));
            if (!mon_r.is_tile) begin
               check("rec_edge_a", 128'(out_edge_a), 128'(mon_r.ea));
               check("rec_edge_b", 128'(out_edge_b), 128'(mon_r.eb));
               check("rec_edge_c", 128'(out_edge_c), 128'(mon_r.ec));
               check("rec_area", 128'(out_area), 128'(mon_r.area));
               check("rec_bbox", 128'(out_bbox), 128'(mon_r.bbox));
               check("rec_attr", 128'(out_attr), 128'(mon_r.attr));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [121:0] w);
      q_words.push_back(w);
      n_push++;
   endtask

   task automatic wait_rd(output int t);
      int n = 0;
      while (!fifo_rd_en && n < 40) begin step(); n++; end
      if (!fifo_rd_en) check("rd_en_timeout", 128'(0), 128'(1));
      t = cyc;
   endtask

   task automatic wait_valid(input int budget, output int t, output bit got);
      int n = 0;
      while (!out_valid && n < budget) begin step(); n++; end
      got = out_valid;
      t = cyc;
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   function automatic logic [37:0] vtx(input int x, input int y);
      logic [25:0] at;
      at = 26'($urandom);
      return {6'(x), 6'(y), at};
   endfunction

   function automatic logic [121:0] tri_w(input int xa, input int ya, input int xb, input int yb,
                                          input int xc, input int yc);
      return {1'b0, 7'($urandom), vtx(xa, ya), vtx(xb, yb), vtx(xc, yc)};
   endfunction

   function automatic logic [121:0] tile_w(input int tx, input int ty);
      return {1'b1, 3'(ty), 4'(tx), 114'({$urandom, $urandom, $urandom, $urandom})};
   endfunction

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d", nvec);
      $fatal(1);
   end

   initial begin
      int t0, t1, n, p;
      bit got;
      logic [201:0] snap;

      repeat (3) step();
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_rd_en", 128'(fifo_rd_en), 128'(0));
      check("rst_cnt", 128'(culled_count), 128'(0));
      check("rst_tile", 128'({out_is_tile, out_tile_x, out_tile_y}), 128'(0));
      rst = 1'b0;
      step();

      // Tile command: 2-cycle latency, single pop
      push(tile_w(9, 3));
      wait_rd(t0);
      wait_valid(10, t1, got);
      check("tile_got", 128'(got), 128'(1));
      check("tile_lat", 128'(t1 - t0), 128'(2));
      check("tile_is_tile", 128'(out_is_tile), 128'(1));
      check("tile_x", 128'(out_tile_x), 128'(9));
      check("tile_y", 128'(out_tile_y), 128'(3));
      accept();
      repeat (4) step();
      check("tile_pops", 128'(rd_cnt), 128'(1));
      check("tile_done", 128'(out_valid), 128'(0));

      // Clockwise reference triangle
      push(tri_w(20, 5, 3, 20, 26, 26));
      wait_rd(t0);
      wait_valid(10, t1, got);
`ifdef BACKFACE_CULL_EN
      check("bf_no_rec", 128'(got), 128'(0));
      check("bf_cull_cnt", 128'(culled_count), 128'(1));
`else
      check("tri1_got", 128'(got), 128'(1));
      check("tri1_lat", 128'(t1 - t0), 128'(6));
      check("tri1_a", 128'(out_edge_a), 128'({7'(15), 7'(6), 7'(-21)}));
      check("tri1_b", 128'(out_edge_b), 128'({7'(17), 7'(-23), 7'(6)}));
      check("tri1_c", 128'(out_edge_c), 128'({13'(-385), 13'(442), 13'(390)}));
      check("tri1_area", 128'(out_area), 128'(447));
      check("tri1_bbox", 128'(out_bbox), 128'({5'd3, 5'd26, 5'd5, 5'd26}));
      accept();
`endif

      // Coordinates at 32 clamp to 31 in the bbox
      push(tri_w(0, 0, 32, 0, 0, 32));
      wait_rd(t0);
      wait_valid(10, t1, got);
      check("tri2_got", 128'(got), 128'(1));
      check("tri2_area", 128'(out_area), 128'(1024));
      check("tri2_bbox", 128'(out_bbox), 128'({5'd0, 5'd31, 5'd0, 5'd31}));
      check("tri2_tile_keep", 128'({out_is_tile, out_tile_x, out_tile_y}), 128'({1'b0, 4'd9, 3'd3}));
      accept();

      // Backpressure: record holds, no pop while waiting
      push(tri_w(2, 2, 20, 4, 8, 25));
      push(tile_w(5, 6));
      wait_rd(t0);
      wait_valid(10, t1, got);
      check("stall_got", 128'(got), 128'(1));
      snap = {out_is_tile, out_tile_x, out_tile_y, out_edge_a, out_edge_b, out_edge_c,
              out_area, out_bbox, out_attr};
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_hold", 128'({out_is_tile, out_tile_x, out_tile_y, out_edge_a, out_edge_b,
                                   out_edge_c, out_area, out_bbox, out_attr} != snap), 128'(0));
         check("stall_rd_en", 128'(fifo_rd_en), 128'(0));
      end
      check("stall_valid", 128'(out_valid), 128'(1));
      out_ready = 1'b1;
      step();
      check("pop_after_accept", 128'(fifo_rd_en), 128'(1));
      check("valid_after_accept", 128'(out_valid), 128'(0));
      wait_valid(10, t1, got);
      check("tile2_got", 128'(got), 128'(1));
      check("tile2_xy", 128'({out_is_tile, out_tile_x, out_tile_y}), 128'({1'b1, 4'd5, 3'd6}));
      step();
      out_ready = 1'b0;

      // Degenerate triangle culls; counter saturates
      push(tri_w(5, 5, 5, 5, 5, 5));
      wait_rd(t0);
      repeat (8) step();
      check("degen_cnt", 128'(culled_count), 128'(m_cnt));
      check("degen_no_valid", 128'(out_valid), 128'(0));
      force dut.cnt_q = 16'hFFFF;
      step();
      release dut.cnt_q;
      m_cnt = 16'hFFFF;
      push(tri_w(5, 5, 5, 5, 5, 5));
      wait_rd(t0);
      repeat (8) step();
      check("sat_cnt", 128'(culled_count), 128'(16'hFFFF));

      // Reset while the edge pipeline is mid-way through a triangle
      push(tri_w(1, 1, 30, 2, 4, 28));
      wait_rd(t0);
      repeat (3) step();
      rst = 1'b1;
      push(tile_w(7, 2));
      push(tri_w(3, 3, 25, 6, 10, 20));
      step();
      check("mid_rst_valid", 128'(out_valid), 128'(0));
      check("mid_rst_rd_en", 128'(fifo_rd_en), 128'(0));
      check("mid_rst_cnt", 128'(culled_count), 128'(0));
      check("mid_rst_tile", 128'({out_tile_x, out_tile_y}), 128'(0));
      step();
      check("mid_rst_rd_en2", 128'(fifo_rd_en), 128'(0));
      exp_q.delete();
      m_cnt = '0; m_tx = '0; m_ty = '0;
      rst = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((q_words.size() != 0 || exp_q.size() != 0) && n < 100) begin step(); n++; end
      repeat (10) step();
      check("post_rst_drain", 128'(q_words.size() + exp_q.size()), 128'(0));
      check("post_rst_tile_x", 128'(out_tile_x), 128'(7));
      check("post_rst_cnt", 128'(culled_count), 128'(m_cnt));

      // Random mix with random backpressure
      p = rd_cnt;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            push(tile_w(int'($urandom_range(0, 15)), int'($urandom_range(0, 7))));
         end else if ($urandom_range(0, 19) == 0) begin
            t0 = int'($urandom_range(0, 63));
            t1 = int'($urandom_range(0, 63));
            push(tri_w(t0, t1, t0, t1, t0, t1));
         end else begin
            push(tri_w(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                       int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                       int'($urandom_range(0, 40)), int'($urandom_range(0, 40))));
         end
      end
      n = 0;
      while ((q_words.size() != 0 || exp_q.size() != 0) && n < 20000) begin
         out_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      out_ready = 1'b1;
      repeat (10) step();
      check("rand_drain", 128'(q_words.size() + exp_q.size()), 128'(0));
      check("rand_pops", 128'(rd_cnt - p), 128'(150));
      check("rand_cnt", 128'(culled_count), 128'(m_cnt));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
